// File: rtl/vc_crossbar_router_pkg.sv
// Shared constants and helpers for the 3x3 val/rdy crossbar router.
//   NUM_PORTS    : number of input and output ports
//   DEST_W       : width of a destination / source index
//   DEST_ILLEGAL : destination code that is accepted and then dropped
//   next_idx3    : increment modulo 3, used by the round-robin pointers
package vc_crossbar_router_pkg;

  localparam int                NUM_PORTS    = 3;
  localparam int                DEST_W       = 2;
  localparam logic [DEST_W-1:0] DEST_ILLEGAL = 2'd3;

  function automatic logic [DEST_W-1:0] next_idx3(input logic [DEST_W-1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/vc_crossbar_router_arb.sv
// Three-way round-robin arbiter with an internal priority pointer.
//   clk, reset : clock, asynchronous active-high reset (pointer -> 0)
//   req_i      : request bit per input
//   en_i       : a transfer completed this cycle; advance the pointer
//   gnt_o      : one-hot grant (all zero when no request)
//   gnt_idx_o  : encoded grant, 0 when no request
module round_robin_arb3
  import vc_crossbar_router_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        req_i,
  input  logic              en_i,
  output logic [2:0]        gnt_o,
  output logic [DEST_W-1:0] gnt_idx_o
);

  logic [DEST_W-1:0] ptr_q;
  logic [DEST_W-1:0] ptr_d;
  logic [DEST_W-1:0] cand_s;

  // Search ptr, ptr+1, ptr+2 (mod 3); first requester wins.
  always_comb begin
    gnt_o     = 3'b000;
    gnt_idx_o = 2'd0;
    cand_s    = ptr_q;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (req_i[cand_s] && (gnt_o == 3'b000)) begin
        gnt_o[cand_s] = 1'b1;
        gnt_idx_o     = cand_s;
      end else begin
        gnt_o = gnt_o;
      end
      cand_s = next_idx3(cand_s);
    end
  end

  // Pointer moves past the winner only when a transfer actually happens,
  // so the presented message stays stable under backpressure.
  always_comb begin
    if (en_i && (req_i != 3'b000)) begin
      ptr_d = next_idx3(gnt_idx_o);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/vc_crossbar_router.sv
// Three-input / three-output val/rdy router stage. Each input owns a
// one-entry buffer; each output has its own round-robin arbiter whose
// encoded grant selects the payload through a 3:1 mux.
//   clk, reset          : clock, asynchronous active-high reset
//   inN_val/rdy/msg/dest: input port N handshake, payload, destination
//   outN_val/rdy/msg/src: output port N handshake, payload, source index
// out_rdy -> in_rdy is a combinational path (through the grant); the
// payload path from input to output is always registered.
module vc_crossbar_router
  import vc_crossbar_router_pkg::*;
#(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in0_val,
  output logic                 in0_rdy,
  input  logic [BIT_WIDTH-1:0] in0_msg,
  input  logic [DEST_W-1:0]    in0_dest,
  input  logic                 in1_val,
  output logic                 in1_rdy,
  input  logic [BIT_WIDTH-1:0] in1_msg,
  input  logic [DEST_W-1:0]    in1_dest,
  input  logic                 in2_val,
  output logic                 in2_rdy,
  input  logic [BIT_WIDTH-1:0] in2_msg,
  input  logic [DEST_W-1:0]    in2_dest,
  output logic                 out0_val,
  input  logic                 out0_rdy,
  output logic [BIT_WIDTH-1:0] out0_msg,
  output logic [DEST_W-1:0]    out0_src,
  output logic                 out1_val,
  input  logic                 out1_rdy,
  output logic [BIT_WIDTH-1:0] out1_msg,
  output logic [DEST_W-1:0]    out1_src,
  output logic                 out2_val,
  input  logic                 out2_rdy,
  output logic [BIT_WIDTH-1:0] out2_msg,
  output logic [DEST_W-1:0]    out2_src
);

  logic [NUM_PORTS-1:0] in_val_s, in_rdy_s, out_rdy_s, out_val_s;
  logic [BIT_WIDTH-1:0] in_msg_s  [NUM_PORTS];
  logic [DEST_W-1:0]    in_dest_s [NUM_PORTS];
  logic [BIT_WIDTH-1:0] out_msg_s [NUM_PORTS];
  logic [DEST_W-1:0]    out_src_s [NUM_PORTS];

  logic [NUM_PORTS-1:0] full_q, full_d;
  logic [BIT_WIDTH-1:0] msg_q  [NUM_PORTS];
  logic [BIT_WIDTH-1:0] msg_d  [NUM_PORTS];
  logic [DEST_W-1:0]    dest_q [NUM_PORTS];
  logic [DEST_W-1:0]    dest_d [NUM_PORTS];

  logic [NUM_PORTS-1:0] req_s   [NUM_PORTS];  // req_s[out][in]
  logic [NUM_PORTS-1:0] gnt_s   [NUM_PORTS];  // gnt_s[out][in]
  logic [DEST_W-1:0]    gnt_idx_s [NUM_PORTS];
  logic [NUM_PORTS-1:0] xfer_s, granted_s, drop_s, load_s;

  assign in_val_s  = {in2_val, in1_val, in0_val};
  assign out_rdy_s = {out2_rdy, out1_rdy, out0_rdy};
  assign in_msg_s[0] = in0_msg;   assign in_dest_s[0] = in0_dest;
  assign in_msg_s[1] = in1_msg;   assign in_dest_s[1] = in1_dest;
  assign in_msg_s[2] = in2_msg;   assign in_dest_s[2] = in2_dest;

  assign in0_rdy = in_rdy_s[0];
  assign in1_rdy = in_rdy_s[1];
  assign in2_rdy = in_rdy_s[2];
  assign out0_val = out_val_s[0]; assign out0_msg = out_msg_s[0]; assign out0_src = out_src_s[0];
  assign out1_val = out_val_s[1]; assign out1_msg = out_msg_s[1]; assign out1_src = out_src_s[1];
  assign out2_val = out_val_s[2]; assign out2_msg = out_msg_s[2]; assign out2_src = out_src_s[2];

  // Request matrix, grant fan-in and input readiness. An illegal-dest
  // entry drains by itself, so it behaves like a grant for in_rdy.
  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        req_s[j][i] = full_q[i] && (dest_q[i] == DEST_W'(j));
      end
      xfer_s[j] = out_val_s[j] && out_rdy_s[j];
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      granted_s[i] = 1'b0;
      for (int j = 0; j < NUM_PORTS; j++) begin
        granted_s[i] = granted_s[i] | (gnt_s[j][i] & out_rdy_s[j]);
      end
      drop_s[i]   = full_q[i] && (dest_q[i] == DEST_ILLEGAL);
      in_rdy_s[i] = !full_q[i] || granted_s[i] || drop_s[i];
      load_s[i]   = in_val_s[i] && in_rdy_s[i];
    end
  end

  // One arbiter per output, pointer advanced on a completed transfer.
  for (genvar gj = 0; gj < NUM_PORTS; gj++) begin : g_arb
    round_robin_arb3 u_arb (
      .clk       (clk),
      .reset     (reset),
      .req_i     (req_s[gj]),
      .en_i      (xfer_s[gj]),
      .gnt_o     (gnt_s[gj]),
      .gnt_idx_o (gnt_idx_s[gj])
    );
  end

  // Output 3:1 mux; payload and source forced to zero when idle.
  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      out_val_s[j] = |req_s[j];
      out_msg_s[j] = {BIT_WIDTH{1'b0}};
      out_src_s[j] = 2'd0;
      if (out_val_s[j]) begin
        out_src_s[j] = gnt_idx_s[j];
        case (gnt_idx_s[j])
          2'd0:    out_msg_s[j] = msg_q[0];
          2'd1:    out_msg_s[j] = msg_q[1];
          2'd2:    out_msg_s[j] = msg_q[2];
          default: out_msg_s[j] = {BIT_WIDTH{1'b0}};
        endcase
      end else begin
        out_src_s[j] = 2'd0;
      end
    end
  end

  // Buffer next state: a new accept wins over a departure in the same cycle.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      full_d[i] = full_q[i];
      msg_d[i]  = msg_q[i];
      dest_d[i] = dest_q[i];
      if (load_s[i]) begin
        full_d[i] = 1'b1;
        msg_d[i]  = in_msg_s[i];
        dest_d[i] = in_dest_s[i];
      end else if (granted_s[i] || drop_s[i]) begin
        full_d[i] = 1'b0;
      end else begin
        full_d[i] = full_q[i];
      end
    end
  end

  // Input buffer registers; reset discards anything buffered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= 3'b000;
      for (int i = 0; i < NUM_PORTS; i++) begin
        msg_q[i]  <= {BIT_WIDTH{1'b0}};
        dest_q[i] <= 2'd0;
      end
    end else begin
      full_q <= full_d;
      for (int i = 0; i < NUM_PORTS; i++) begin
        msg_q[i]  <= msg_d[i];
        dest_q[i] <= dest_d[i];
      end
    end
  end

endmodule

// File: tb/tb_vc_crossbar_router.sv
module tb_vc_crossbar_router;

  typedef struct packed {
    logic [31:0] msg;
    logic [1:0]  src;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  in_val, in_rdy, out_val, out_rdy;
  logic [31:0] in_msg  [3];
  logic [1:0]  in_dest [3];
  logic [31:0] out_msg [3];
  logic [1:0]  out_src [3];

  exp_t sb_q [3][$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  vc_crossbar_router #(.BIT_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .in0_val(in_val[0]), .in0_rdy(in_rdy[0]), .in0_msg(in_msg[0]), .in0_dest(in_dest[0]),
    .in1_val(in_val[1]), .in1_rdy(in_rdy[1]), .in1_msg(in_msg[1]), .in1_dest(in_dest[1]),
    .in2_val(in_val[2]), .in2_rdy(in_rdy[2]), .in2_msg(in_msg[2]), .in2_dest(in_dest[2]),
    .out0_val(out_val[0]), .out0_rdy(out_rdy[0]), .out0_msg(out_msg[0]), .out0_src(out_src[0]),
    .out1_val(out_val[1]), .out1_rdy(out_rdy[1]), .out1_msg(out_msg[1]), .out1_src(out_src[1]),
    .out2_val(out_val[2]), .out2_rdy(out_rdy[2]), .out2_msg(out_msg[2]), .out2_src(out_src[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int j, input logic [31:0] m, input logic [1:0] s);
    exp_t e;
    e.msg = m;
    e.src = s;
    sb_q[j].push_back(e);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completed output transfer must match the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      for (int j = 0; j < 3; j++) begin
        if (out_val[j] && out_rdy[j]) begin
          if (sb_q[j].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out%0d: got msg %h src %0d expected nothing", j, out_msg[j], out_src[j]);
          end else begin
            exp_t e;
            e = sb_q[j].pop_front();
            chk($sformatf("out%0d_msg", j), out_msg[j], e.msg);
            chk($sformatf("out%0d_src", j), 32'(out_src[j]), 32'(e.src));
          end
        end
      end
    end
  end

  initial begin
    int          k [3];
    logic [2:0]  acc;
    logic [2:0]  exp_rdy [4];
    logic [1:0]  perm [3];

    reset   = 1'b1;
    in_val  = 3'b000;
    out_rdy = 3'b000;
    for (int i = 0; i < 3; i++) begin
      in_msg[i]  = 32'h0;
      in_dest[i] = 2'd0;
    end
    #1;
    chk("reset_out_val", 32'(out_val), 32'h0);
    chk("reset_in_rdy", 32'(in_rdy), 32'h7);
    chk("reset_out_msg", out_msg[1], 32'h0);
    chk("reset_out_src", 32'(out_src[2]), 32'h0);
    cycle();
    reset = 1'b0;

    // Single path: in1 -> out2.
    out_rdy    = 3'b111;
    in_val[1]  = 1'b1;
    in_msg[1]  = 32'hA5A5_0001;
    in_dest[1] = 2'd2;
    push(2, 32'hA5A5_0001, 2'd1);
    chk("single_in1_rdy", 32'(in_rdy[1]), 32'h1);
    cycle();
    in_val[1] = 1'b0;
    chk("single_out2_val", 32'(out_val[2]), 32'h1);
    chk("single_out2_msg", out_msg[2], 32'hA5A5_0001);
    chk("single_out2_src", 32'(out_src[2]), 32'h1);
    chk("single_others_idle", 32'(out_val[1:0]), 32'h0);
    cycle();
    chk("single_out2_done", 32'(out_val[2]), 32'h0);

    // Three-way contention on out0; pointer at 0 so order 0,1,2,0,1,2.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin
        push(0, 32'hC000_0000 | (32'(i) << 8) | 32'(r), 2'(i));
      end
    end
    exp_rdy[0] = 3'b001; exp_rdy[1] = 3'b010; exp_rdy[2] = 3'b100; exp_rdy[3] = 3'b001;
    for (int i = 0; i < 3; i++) k[i] = 0;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < 3; i++) begin
        in_val[i]  = (k[i] < 2);
        in_msg[i]  = 32'hC000_0000 | (32'(i) << 8) | 32'(k[i]);
        in_dest[i] = 2'd0;
      end
      if (c >= 1 && c <= 4) chk($sformatf("contend_in_rdy_c%0d", c), 32'(in_rdy), 32'(exp_rdy[c-1]));
      acc = in_val & in_rdy;
      cycle();
      for (int i = 0; i < 3; i++) k[i] += int'(acc[i]);
    end
    in_val = 3'b000;

    // Backpressure on out1 with in2 buffered.
    out_rdy    = 3'b101;
    in_val[2]  = 1'b1;
    in_msg[2]  = 32'hB000_0002;
    in_dest[2] = 2'd1;
    cycle();
    in_val[2] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("bp_out1_val", 32'(out_val[1]), 32'h1);
      chk("bp_out1_msg", out_msg[1], 32'hB000_0002);
      chk("bp_in2_rdy", 32'(in_rdy[2]), 32'h0);
      if (c < 3) cycle();
    end
    push(1, 32'hB000_0002, 2'd2);
    out_rdy[1] = 1'b1;
    cycle();
    chk("bp_out1_drained", 32'(out_val[1]), 32'h0);
    // Pointer on out1 is now 0: in1 must beat in2.
    in_val[1] = 1'b1; in_msg[1] = 32'hB100_0001; in_dest[1] = 2'd1;
    in_val[2] = 1'b1; in_msg[2] = 32'hB200_0002; in_dest[2] = 2'd1;
    push(1, 32'hB100_0001, 2'd1);
    push(1, 32'hB200_0002, 2'd2);
    cycle();
    in_val = 3'b000;
    cycle();
    cycle();

    // Permutation: in0->2, in1->0, in2->1, three messages each.
    perm[0] = 2'd2; perm[1] = 2'd0; perm[2] = 2'd1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) push(int'(perm[i]), 32'hD000_0000 | (32'(i) << 8) | 32'(r), 2'(i));
    end
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) begin
        in_val[i]  = 1'b1;
        in_msg[i]  = 32'hD000_0000 | (32'(i) << 8) | 32'(r);
        in_dest[i] = perm[i];
      end
      chk($sformatf("perm_in_rdy_r%0d", r), 32'(in_rdy), 32'h7);
      if (r > 0) chk($sformatf("perm_out_val_r%0d", r), 32'(out_val), 32'h7);
      cycle();
    end
    in_val = 3'b000;
    chk("perm_out_val_last", 32'(out_val), 32'h7);
    cycle();

    // Illegal destination on in0, then a legal message.
    in_val[0]  = 1'b1;
    in_msg[0]  = 32'hEEEE_0000;
    in_dest[0] = 2'd3;
    cycle();
    chk("illegal_no_out", 32'(out_val), 32'h0);
    chk("illegal_in0_rdy", 32'(in_rdy[0]), 32'h1);
    in_msg[0]  = 32'h1234_5678;
    in_dest[0] = 2'd0;
    push(0, 32'h1234_5678, 2'd0);
    cycle();
    in_val[0] = 1'b0;
    chk("illegal_next_val", 32'(out_val), 32'h1);
    chk("illegal_next_src", 32'(out_src[0]), 32'h0);
    cycle();

    // Reset with all buffers full and outputs stalled.
    out_rdy = 3'b000;
    in_val  = 3'b111;
    for (int i = 0; i < 3; i++) begin
      in_msg[i]  = 32'hF000_0000 | 32'(i);
      in_dest[i] = 2'(i);
    end
    cycle();
    in_val = 3'b000;
    chk("rst_pre_out_val", 32'(out_val), 32'h7);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_out_val", 32'(out_val), 32'h0);
    chk("rst_mid_in_rdy", 32'(in_rdy), 32'h7);
    chk("rst_mid_out_msg", out_msg[0], 32'h0);
    #2;
    reset   = 1'b0;
    out_rdy = 3'b111;
    for (int c = 0; c < 3; c++) cycle();
    chk("rst_post_out_val", 32'(out_val), 32'h0);

    for (int j = 0; j < 3; j++) chk($sformatf("sb%0d_empty", j), 32'(sb_q[j].size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vc_crossbar_router.md
# vc_crossbar_router

Three-input, three-output val/rdy message router that sits in front of the combinational 3x3 crossbar datapath and supplies its per-output selects. Each input port carries a payload plus a 2-bit destination; the block registers one message per input, arbitrates round-robin per output among contending inputs, and drives each output port through a 3:1 mux. It turns the stateless select-driven crossbar into a flow-controlled, contention-resolving network stage.

## Interface
- BIT_WIDTH, 32, payload width of every message
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in{0,1,2}_val  input  1  message valid on input port i
- in{0,1,2}_rdy  output  1  input port i can accept this cycle
- in{0,1,2}_msg  input  BIT_WIDTH  payload
- in{0,1,2}_dest  input  2  destination output port; 0..2 legal, 3 illegal
- out{0,1,2}_val  output  1  message valid on output port j
- out{0,1,2}_rdy  input  1  downstream on port j accepts this cycle
- out{0,1,2}_msg  output  BIT_WIDTH  payload
- out{0,1,2}_src  output  2  input index the presented message came from

## Operation
- Per input i: one-entry buffer {full_i, msg_i, dest_i}. Transfer on input when in_val && in_rdy; transfer on output when out_val && out_rdy.
- in_rdy_i = !full_i || granted_i (granted_i = buffer i wins its output and that output's rdy is high this cycle). Back-to-back accept at full throughput when not contended.
- Buffer update: accept and grant same cycle -> load new message, full stays 1; grant only -> full=0; accept only -> full=1.
- Request: input i requests output j iff full_i && dest_i == j.
- Per output j: round-robin arbiter over 3 requests. Priority pointer ptr_j in {0,1,2}; search order ptr_j, ptr_j+1, ptr_j+2 mod 3. out_val_j = any request; out_msg_j/out_src_j from winner; out_msg_j = 0, out_src_j = 0 when out_val_j = 0.
- Pointer update only on a completed transfer (out_val_j && out_rdy_j): ptr_j <= (winner+1) mod 3. No transfer -> pointer holds; winner may change only if request set changes (a new request cannot appear while buffers are stalled, so output is stable under backpressure).
- dest == 3: message accepted, dropped on the following cycle (buffer clears, no output asserted). No error output.
- Each output arbitrates independently; inputs targeting different outputs move in the same cycle.

## Timing
- Reset (async assert): all full_i = 0, all ptr_j = 0, so all out_val = 0, out_msg = 0, out_src = 0, all in_rdy = 1 immediately.
- Latency: message accepted at edge N is visible on output at cycle N+1 (after edge N); minimum one cycle, no combinational in->out payload path.
- Combinational path out_rdy_j -> in_rdy_i exists (through grant); documented, intentional.
- Throughput: one message per output per cycle; under full 3-way contention each input gets 1 of every 3 transfers.
- Reset mid-operation: buffered messages are discarded, not delivered.

## Structure
- Shared package: NUM_PORTS = 3, DEST_W = 2, DEST_ILLEGAL = 2'd3.
- Sub-module round_robin_arb3: 3 request bits, enable (= transfer), one-hot grant, internal pointer with async reset to 0; instantiated once per output.
- Output datapath reuses the existing three-input mux with the arbiter's encoded grant as select.

## Test plan
- Reset: assert reset mid-cycle with all buffers full -> all out_val = 0, all in_rdy = 1 before next edge; post-reset nothing emitted.
- Single path: in1 sends 0xA5A5_0001 dest 2, out2_rdy=1 -> out2_val=1, out2_msg=0xA5A5_0001, out2_src=1 exactly one cycle later; other outputs idle.
- Contention: in0,in1,in2 all stream dest 0 each cycle, out0_rdy=1 -> out0_src sequence 0,1,2,0,1,2; each in_rdy high one cycle in three.
- Backpressure: in2 dest 1 buffered, out1_rdy=0 for 4 cycles -> out1_val and out1_msg held stable, in2_rdy=0; release -> delivered once, ptr_1 becomes 0.
- Parallel/permutation: in0->2, in1->0, in2->1 simultaneously, all rdy=1 -> all three outputs valid next cycle with correct src; sustained 3 msgs/cycle.
- Illegal dest: in0 sends dest 3 -> accepted, no out_val on any port, in0_rdy remains 1, next legal message on in0 delivered normally.
